block_fetch: RTL and testbench

Reads the stored image out of the `pc2mem` image RAM in 8x8 block order and streams it as 8-bit pixels to the downstream DCT stage. It drives the RAM read port and covers the RAM's one-cycle registered read latency. It unpacks each 32-bit word into four pixels and applies valid/ready back-pressure without losing or duplicating data. One `start` pulse fetches one full frame.

---
 rtl/block_fetch.sv | 139 +++++++++++++
 tb/tb_block_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/block_fetch.sv
// block_fetch: reads the image RAM in 8x8 block order and streams it out as 8-bit pixels
module block_fetch #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] q,
   output logic [7:0]            pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  blk_first,
   output logic                  blk_last,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int WPR = IMG_W / 4;
   localparam int NBX = IMG_W / 8;
   localparam int NBY = IMG_H / 8;
   localparam int XW  = $clog2(NBX + 1);
   localparam int YW  = $clog2(NBY + 1);
   localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(WPR - 1);
   localparam logic [ADDR_WIDTH-1:0] BLK_BACK = ADDR_WIDTH'(7 * WPR - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] naddr;
   logic                  wsel;
   logic [2:0]            row;
   logic [XW-1:0]         bx;
   logic [YW-1:0]         by;
   logic                  pend1, pend2;
   logic [DATA_WIDTH-1:0] wbuf [2];
   logic [DATA_WIDTH-1:0] head;
   logic                  hd, tl;
   logic [1:0]            cnt;
   logic [1:0]            pidx;
   logic [5:0]            pcnt;
   logic                  go, last_word, issue, accept, pop, push, final_px;

   assign go        = state == IDLE && start && !frame_done;
   assign last_word = wsel && row == 3'd7 && bx == XW'(NBX - 1) && by == YW'(NBY - 1);
   assign issue     = go || (state == FETCH && (3'(cnt) + 3'(pend1) + 3'(pend2)) < 3'd2);
   assign push      = pend2;
   assign pix_valid = cnt != 2'd0;
   assign accept    = pix_valid && pix_ready;
   assign pop       = accept && pidx == 2'd3;
   assign final_px  = state == DRAIN && pop && cnt == 2'd1 && !pend1 && !pend2;
   assign head      = wbuf[hd] << {pidx, 3'b000};
   assign pix_data  = head[DATA_WIDTH-1 -: 8];
   assign blk_first = pix_valid && pcnt == 6'd0;
   assign blk_last  = pix_valid && pcnt == 6'd63;

   // frame sequencing, block-order address walk and read-latency tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         read_addr  <= '0;
         naddr      <= '0;
         wsel       <= 1'b0;
         row        <= '0;
         bx         <= '0;
         by         <= '0;
         pend1      <= 1'b0;
         pend2      <= 1'b0;
      end else begin
         pend1      <= issue;
         pend2      <= pend1;
         frame_done <= final_px;
         if (issue) begin
            read_addr <= naddr;
            wsel      <= !wsel;
            if (last_word) begin
               naddr <= '0;
               row   <= '0;
               bx    <= '0;
               by    <= '0;
            end else if (!wsel) begin
               naddr <= naddr + ADDR_WIDTH'(1);
            end else if (row != 3'd7) begin
               naddr <= naddr + ROW_STEP;
               row   <= row + 3'd1;
            end else if (bx != XW'(NBX - 1)) begin
               naddr <= naddr - BLK_BACK;
               row   <= '0;
               bx    <= bx + XW'(1);
            end else begin
               naddr <= naddr + ADDR_WIDTH'(1);
               row   <= '0;
               bx    <= '0;
               by    <= by + YW'(1);
            end
         end
         case (state)
            IDLE:    if (go) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                     end
            FETCH:   if (issue && last_word) state <= DRAIN;
            DRAIN:   if (final_px) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
            default: state <= IDLE;
         endcase
      end
   end

   // two-word buffer filled from the RAM pipe and drained four pixels per word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbuf[0] <= '0;
         wbuf[1] <= '0;
         hd      <= 1'b0;
         tl      <= 1'b0;
         cnt     <= '0;
         pidx    <= '0;
         pcnt    <= '0;
      end else begin
         if (push) begin
            wbuf[tl] <= q;
            tl       <= !tl;
         end
         if (pop) hd <= !hd;
         cnt <= cnt + 2'(push) - 2'(pop);
         if (accept) begin
            pidx <= pidx + 2'd1;
            pcnt <= pcnt + 6'd1;
         end
      end
   end
endmodule

// File: tb/tb_block_fetch.sv
// tb_block_fetch: scoreboard bench for block_fetch on a 64x16 image
module tb_block_fetch;
   localparam int W     = 64;
   localparam int H     = 16;
   localparam int WORDS = W * H / 4;
   localparam int PIX   = W * H;
   localparam int BLKS  = (W / 8) * (H / 8);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        pix_ready = 1'b1;
   logic [15:0] read_addr;
   logic [31:0] q = '0;
   logic [7:0]  pix_data;
   logic        pix_valid, blk_first, blk_last, busy, frame_done;

   logic [31:0] mem [WORDS];
   logic [9:0]  exp_q [$];
   int          alog [$];
   int          errors = 0;
   int          checks = 0;
   int          acc = 0, acc_f = 0, nlast = 0, nfd = 0;
   logic        mon_en = 1'b0;

   block_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .read_addr(read_addr), .q(q),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .blk_first(blk_first), .blk_last(blk_last), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // registered-read RAM model
   always @(posedge clk) q <= mem[read_addr[7:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      for (int by = 0; by < H / 8; by++)
         for (int bx = 0; bx < W / 8; bx++)
            for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++) begin
                  int x = bx * 8 + c;
                  int y = by * 8 + r;
                  logic [31:0] wd = mem[y * (W / 4) + x / 4];
                  exp_q.push_back({r == 0 && c == 0, r == 7 && c == 7, wd[31 - 8 * (x % 4) -: 8]});
               end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic zero_outputs(input string tag);
      chk({tag, "_read_addr"}, 32'(read_addr), 0);
      chk({tag, "_pix_data"}, 32'(pix_data), 0);
      chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
      chk({tag, "_blk_first"}, 32'(blk_first), 0);
      chk({tag, "_blk_last"}, 32'(blk_last), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_frame_done"}, 32'(frame_done), 0);
   endtask

   task automatic wait_done(input bit bp);
      bit got = 1'b0;
      for (int k = 0; k < 8000 && !got; k++) begin
         @(posedge clk);
         #1;
         got = frame_done;
         if (!got && bp) pix_ready = (k >= 40 && k < 50) ? 1'b0 : (($urandom & 3) != 0);
      end
      pix_ready = 1'b1;
      chk("frame_done_seen", 32'(got), 1);
   endtask

   task automatic frame_checks(input int a0, input int l0, input int f0);
      int idx = 0;
      chk("pixels_accepted", 32'(acc - a0), PIX);
      chk("blk_last_count", 32'(nlast - l0), BLKS);
      chk("frame_done_pulses", 32'(nfd - f0), 1);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      chk("reads_issued", 32'(alog.size()), WORDS);
      for (int by = 0; by < H / 8; by++)
         for (int bx = 0; bx < W / 8; bx++)
            for (int r = 0; r < 8; r++)
               for (int w = 0; w < 2; w++) begin
                  if (idx < alog.size()) chk("read_addr_seq", alog[idx], (by * 8 + r) * (W / 4) + bx * 2 + w);
                  idx++;
               end
   endtask

   // output monitor: logs issued addresses and scores every offered pixel
   initial begin
      logic prev_busy = 1'b0;
      logic stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (busy && !prev_busy) begin
               alog.delete();
               alog.push_back(int'(read_addr));
               acc_f = 0;
            end else if (busy && int'(read_addr) != alog[$]) begin
               alog.push_back(int'(read_addr));
            end
            if (stalled) chk("stall_valid_held", 32'(pix_valid), 1);
            if (pix_valid) begin
               if (exp_q.size() == 0) chk("extra_pixel", 1, 0);
               else chk("pixel", {22'd0, blk_first, blk_last, pix_data}, {22'd0, exp_q[0]});
               if (pix_ready) begin
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  acc++;
                  acc_f++;
                  if (blk_last) nlast++;
               end
            end
            stalled = pix_valid && !pix_ready;
            if (busy) chk("outstanding_words", 32'(alog.size() - acc_f / 4 <= 2), 1);
            if (frame_done) nfd++;
         end
         prev_busy = busy;
      end
   end

   initial begin
      int a0, l0, f0;
      logic bad;
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h11223344;
      repeat (3) @(posedge clk);
      #1;
      zero_outputs("reset");
      rst_n  = 1'b1;
      mon_en = 1'b1;

      push_frame();
      a0 = acc;
      l0 = nlast;
      f0 = nfd;
      pulse_start();
      @(negedge clk);
      chk("e0_busy", 32'(busy), 1);
      chk("e0_valid", 32'(pix_valid), 0);
      chk("e0_addr", 32'(read_addr), 0);
      @(negedge clk);
      chk("e1_valid", 32'(pix_valid), 0);
      chk("e1_addr", 32'(read_addr), 1);
      @(negedge clk);
      chk("e2_valid", 32'(pix_valid), 1);
      chk("e2_pix", 32'(pix_data), 32'h11);
      chk("e2_first", 32'(blk_first), 1);
      repeat (20) @(posedge clk);
      #1;
      pulse_start();
      wait_done(1'b0);
      pulse_start();
      chk("start_on_done_busy", 32'(busy), 0);
      chk("start_on_done_pulse", 32'(frame_done), 0);
      frame_checks(a0, l0, f0);

      push_frame();
      a0 = acc;
      l0 = nlast;
      f0 = nfd;
      pulse_start();
      @(negedge clk);
      chk("restart_busy", 32'(busy), 1);
      chk("restart_addr", 32'(read_addr), 0);
      wait_done(1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("idle_busy", 32'(busy), 0);
      frame_checks(a0, l0, f0);

      mon_en = 1'b0;
      exp_q.delete();
      pulse_start();
      repeat (30) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      zero_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (pix_valid || busy) bad = 1'b1;
      end
      chk("quiet_after_reset", 32'(bad), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
